vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator for the Pong display path. It produces horizontal/vertical position, sync, active-video and line/frame start strobes for any mode described by its porch/sync parameters. An internal pixel-enable divider lets it run from a faster system clock. It drives the pixel/object renderer and the VGA output pins, and its default parameters give 640x480 @ 60 Hz at a 25.175 MHz pixel rate.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A clock divider produces one
//   pixel tick every CLK_DIV clk cycles; on each tick the (hcount, vcount)
//   raster position advances and every region output is re-decoded from the
//   position being loaded, so all outputs are coherent on the same cycle.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   pix_en       one-clk pulse marking each pixel tick
//   hcount       horizontal position, 0..H_TOTAL-1
//   vcount       vertical position, 0..V_TOTAL-1
//   hsync        horizontal sync at pin polarity (HSYNC_POL = asserted level)
//   vsync        vertical sync at pin polarity (VSYNC_POL = asserted level)
//   active       high while hcount < H_ACTIVE and vcount < V_ACTIVE
//   line_start   one-clk strobe when the position enters hcount == 0
//   frame_start  one-clk strobe when the position enters (0,0)
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CLK_DIV   = 1,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Sync window bounds kept as 32-bit values: the end bound may equal
    // H_TOTAL/V_TOTAL, which need not fit in CW bits.
    localparam int H_SYNC_BEG = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END = V_ACTIVE + V_FRONT + V_SYNC;

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic          tick;
    logic          h_wrap;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          active_nxt;

    always_comb begin
        tick    = (div == DIV_LAST);
        div_nxt = tick ? '0 : div + DW'(1);

        h_wrap = (hcount == H_LAST);
        h_nxt  = h_wrap ? '0 : hcount + CW'(1);
        if (h_wrap) begin
            v_nxt = (vcount == V_LAST) ? '0 : vcount + CW'(1);
        end else begin
            v_nxt = vcount;
        end

        // Regions are decoded from the position about to be loaded so the
        // registered outputs line up with hcount/vcount.
        hsync_nxt  = (32'(h_nxt) >= H_SYNC_BEG && 32'(h_nxt) < H_SYNC_END) ? HS_ON : ~HS_ON;
        vsync_nxt  = (32'(v_nxt) >= V_SYNC_BEG && 32'(v_nxt) < V_SYNC_END) ? VS_ON : ~VS_ON;
        active_nxt = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            active      <= 1'b1;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div <= div_nxt;
            if (tick) begin
                hcount      <= h_nxt;
                vcount      <= v_nxt;
                hsync       <= hsync_nxt;
                vsync       <= vsync_nxt;
                active      <= active_nxt;
                pix_en      <= 1'b1;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end else begin
                // Strobes last one clk; the rest of the pixel holds position.
                pix_en      <= 1'b0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Four instances run side by side from one clock and one reset:
//     0: default 640x480 mode
//     1: default horizontal timing, short frame (V = 10/2/3/5, V_TOTAL 20)
//     2: tiny mode H = 4/1/2/1, V = 3/1/1/1, positive sync polarities
//     3: default mode with CLK_DIV = 2
//   A background scoreboard predicts every output of every instance each
//   cycle from a closed-form raster model (position = clk count / CLK_DIV,
//   taken modulo the frame size) and compares after the edge. The scenario
//   tasks measure specific timing features directly.
module tb_vga_timing_gen;

    localparam int NI = 4;
    localparam int OW = 28;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int hp, vp, dv;
    } cfg_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [10:0] hc [NI];
    logic [10:0] vc [NI];
    logic        pe [NI];
    logic        hs [NI];
    logic        vs [NI];
    logic        ac [NI];
    logic        ls [NI];
    logic        fs [NI];
    logic [OW-1:0] obs [NI];

    logic [NI*OW-1:0] exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen u0 (
        .clk(clk), .reset(reset), .pix_en(pe[0]), .hcount(hc[0]), .vcount(vc[0]),
        .hsync(hs[0]), .vsync(vs[0]), .active(ac[0]), .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_gen #(
        .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(3), .V_BACK(5)
    ) u1 (
        .clk(clk), .reset(reset), .pix_en(pe[1]), .hcount(hc[1]), .vcount(vc[1]),
        .hsync(hs[1]), .vsync(vs[1]), .active(ac[1]), .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u2 (
        .clk(clk), .reset(reset), .pix_en(pe[2]), .hcount(hc[2]), .vcount(vc[2]),
        .hsync(hs[2]), .vsync(vs[2]), .active(ac[2]), .line_start(ls[2]), .frame_start(fs[2])
    );

    vga_timing_gen #(
        .CLK_DIV(2)
    ) u3 (
        .clk(clk), .reset(reset), .pix_en(pe[3]), .hcount(hc[3]), .vcount(vc[3]),
        .hsync(hs[3]), .vsync(vs[3]), .active(ac[3]), .line_start(ls[3]), .frame_start(fs[3])
    );

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            obs[i] = {hc[i], vc[i], pe[i], hs[i], vs[i], ac[i], ls[i], fs[i]};
        end
    end

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
        case (i)
            1: begin c.va = 10; c.vf = 2; c.vs = 3; c.vb = 5; end
            2: c = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 1};
            3: c.dv = 2;
            default: ;
        endcase
        return c;
    endfunction

    // k = number of clk edges since the last edge that sampled reset high.
    function automatic logic [OW-1:0] model(input int i, input int k);
        cfg_t c;
        int ht, vt, p, h, v;
        logic pev, hsa, vsa, hsv, vsv, act;
        c   = get_cfg(i);
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        p   = (k / c.dv) % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        pev = (k > 0) && ((k % c.dv) == 0);
        hsa = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
        vsa = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
        hsv = hsa ? (c.hp != 0) : (c.hp == 0);
        vsv = vsa ? (c.vp != 0) : (c.vp == 0);
        act = (h < c.ha) && (v < c.va);
        return {11'(h), 11'(v), pev, hsv, vsv, act, pev && (h == 0), pev && (h == 0) && (v == 0)};
    endfunction

    task automatic scoreboard();
        logic [NI*OW-1:0] e;
        cfg_t c;
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            k = reset ? 0 : k + 1;
            for (int i = 0; i < NI; i++) e[i*OW +: OW] = model(i, k);
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                c = get_cfg(i);
                checks++;
                if (obs[i] !== e[i*OW +: OW]) begin
                    errors++;
                    if (errors < 40)
                        $display("FAIL sb_inst%0d k=%0d: got h=%0d v=%0d flags=%b expected h=%0d v=%0d flags=%b",
                                 i, k, obs[i][27:17], obs[i][16:6], obs[i][5:0],
                                 e[i*OW+17 +: 11], e[i*OW+6 +: 11], e[i*OW +: 6]);
                end
                checks++;
                if (!(int'(hc[i]) < c.ha + c.hf + c.hs + c.hb && int'(vc[i]) < c.va + c.vf + c.vs + c.vb)) begin
                    errors++;
                    if (errors < 40) $display("FAIL range_inst%0d: got h=%0d v=%0d", i, hc[i], vc[i]);
                end
                checks++;
                if (fs[i] === 1'b1 && ls[i] !== 1'b1) begin
                    errors++;
                    if (errors < 40) $display("FAIL fs_implies_ls_inst%0d: got ls=%b required 1", i, ls[i]);
                end
                checks++;
                if (ac[i] === 1'b1 && (hs[i] === (c.hp != 0) || vs[i] === (c.vp != 0))) begin
                    errors++;
                    if (errors < 40) $display("FAIL active_in_sync_inst%0d: got hs=%b vs=%b with active", i, hs[i], vs[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs[0] !== {11'd0, 11'd0, 6'b011100}) begin
            errors++;
            $display("FAIL reset_default: got %h required %h", obs[0], {11'd0, 11'd0, 6'b011100});
        end
        checks++;
        if (obs[2] !== {11'd0, 11'd0, 6'b000100}) begin
            errors++;
            $display("FAIL reset_pos_pol: got %h required %h", obs[2], {11'd0, 11'd0, 6'b000100});
        end
        checks++;
        if (obs[3] !== {11'd0, 11'd0, 6'b011100}) begin
            errors++;
            $display("FAIL reset_div2: got %h required %h", obs[3], {11'd0, 11'd0, 6'b011100});
        end
        reset = 1'b0;
    endtask

    // Default mode, first lines after release.
    task automatic test_default_hsync();
        int fall_h, rise_h, act_h, low_cnt, ls_first, ls_second, ls_v;
        logic prev_hs, prev_ac;
        fall_h = -1; rise_h = -1; act_h = -1; low_cnt = 0;
        ls_first = -1; ls_second = -1; ls_v = -1;
        prev_hs = 1'b1; prev_ac = 1'b1;
        for (int cyc = 1; cyc <= 1700; cyc++) begin
            @(negedge clk);
            if (prev_hs && !hs[0] && fall_h < 0) fall_h = int'(hc[0]);
            if (!hs[0] && rise_h < 0) low_cnt++;
            if (!prev_hs && hs[0] && rise_h < 0) rise_h = int'(hc[0]);
            if (prev_ac && !ac[0] && act_h < 0) act_h = int'(hc[0]);
            if (ls[0]) begin
                if (ls_first < 0) begin
                    ls_first = cyc;
                    ls_v = int'(vc[0]);
                end else if (ls_second < 0) begin
                    ls_second = cyc;
                end
            end
            prev_hs = hs[0];
            prev_ac = ac[0];
        end
        checks++;
        if (fall_h != 656) begin errors++; $display("FAIL hsync_fall_h: got %0d required 656", fall_h); end
        checks++;
        if (low_cnt != 96) begin errors++; $display("FAIL hsync_low_clk: got %0d required 96", low_cnt); end
        checks++;
        if (rise_h != 752) begin errors++; $display("FAIL hsync_rise_h: got %0d required 752", rise_h); end
        checks++;
        if (act_h != 640) begin errors++; $display("FAIL active_fall_h: got %0d required 640", act_h); end
        checks++;
        if (ls_first != 800 || ls_v != 1) begin
            errors++;
            $display("FAIL first_line_start: got cyc=%0d v=%0d required cyc=800 v=1", ls_first, ls_v);
        end
        checks++;
        if (ls_second - ls_first != 800) begin
            errors++;
            $display("FAIL line_spacing_default: got %0d required 800", ls_second - ls_first);
        end
    endtask

    // CLK_DIV = 2 instance.
    task automatic test_div2();
        int alt_bad, hold_bad, width_bad, ls_a, ls_b;
        logic prev_pe, prev_ls;
        logic [10:0] prev_hc;
        alt_bad = 0; hold_bad = 0; width_bad = 0; ls_a = -1; ls_b = -1;
        @(negedge clk);
        prev_pe = pe[3]; prev_ls = ls[3]; prev_hc = hc[3];
        for (int cyc = 1; cyc <= 3300; cyc++) begin
            @(negedge clk);
            if (pe[3] === prev_pe) alt_bad++;
            if (hc[3] !== prev_hc && pe[3] !== 1'b1) hold_bad++;
            if (ls[3] && prev_ls) width_bad++;
            if (ls[3]) begin
                if (ls_a < 0) ls_a = cyc;
                else if (ls_b < 0) ls_b = cyc;
            end
            prev_pe = pe[3]; prev_ls = ls[3]; prev_hc = hc[3];
        end
        checks++;
        if (alt_bad != 0) begin errors++; $display("FAIL div2_pix_en_alt: got %0d bad cycles required 0", alt_bad); end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL div2_hold: got %0d bad cycles required 0", hold_bad); end
        checks++;
        if (width_bad != 0) begin errors++; $display("FAIL div2_strobe_width: got %0d bad cycles required 0", width_bad); end
        checks++;
        if (ls_a < 0 || ls_b - ls_a != 1600) begin
            errors++;
            $display("FAIL div2_line_period: got %0d required 1600", ls_b - ls_a);
        end
    endtask

    // Tiny positive-polarity mode; DIV 1 so 48 cycles visit every position once.
    task automatic test_small_mode();
        int act_cnt, fs_cnt, hs_bad, vs_bad;
        act_cnt = 0; fs_cnt = 0; hs_bad = 0; vs_bad = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(negedge clk);
            if (ac[2]) act_cnt++;
            if (fs[2]) fs_cnt++;
            if (hs[2] !== (hc[2] >= 11'd5 && hc[2] <= 11'd6)) hs_bad++;
            if (vs[2] !== (vc[2] == 11'd4)) vs_bad++;
        end
        checks++;
        if (act_cnt != 12) begin errors++; $display("FAIL small_active_count: got %0d required 12", act_cnt); end
        checks++;
        if (fs_cnt != 1) begin errors++; $display("FAIL small_frame_count: got %0d required 1", fs_cnt); end
        checks++;
        if (hs_bad != 0) begin errors++; $display("FAIL small_hsync_window: got %0d bad required 0", hs_bad); end
        checks++;
        if (vs_bad != 0) begin errors++; $display("FAIL small_vsync_window: got %0d bad required 0", vs_bad); end
    endtask

    // Short-frame instance: two frame_starts, line spacing, vsync width, wrap.
    task automatic test_two_frames();
        int fs_a, fs_b, last_ls, ls_bad, vs_low, vs_bad, wraps, cyc;
        logic [10:0] prev_vc;
        fs_a = -1; fs_b = -1; last_ls = -1; ls_bad = 0; vs_low = 0; vs_bad = 0; wraps = 0;
        prev_vc = vc[1];
        cyc = 0;
        while (fs_b < 0 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (ls[1]) begin
                if (last_ls >= 0 && cyc - last_ls != 800) ls_bad++;
                last_ls = cyc;
            end
            if (!vs[1] && !(vc[1] >= 11'd12 && vc[1] <= 11'd14)) vs_bad++;
            if (fs_a >= 0) begin
                if (prev_vc == 11'd19 && vc[1] == 11'd0) wraps++;
            end
            if (fs[1]) begin
                if (fs_a < 0) fs_a = cyc;
                else fs_b = cyc;
            end
            if (fs_a >= 0 && fs_b < 0 && !vs[1]) vs_low++;
            prev_vc = vc[1];
        end
        checks++;
        if (fs_b < 0 || fs_b - fs_a != 16000) begin
            errors++;
            $display("FAIL frame_period: got %0d required 16000 (timeout=%0d)", fs_b - fs_a, fs_b < 0);
        end
        checks++;
        if (ls_bad != 0) begin errors++; $display("FAIL line_spacing_frames: got %0d bad required 0", ls_bad); end
        checks++;
        if (vs_low != 2400) begin errors++; $display("FAIL vsync_low_clk: got %0d required 2400", vs_low); end
        checks++;
        if (vs_bad != 0) begin errors++; $display("FAIL vsync_window: got %0d bad required 0", vs_bad); end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL vcount_wrap: got %0d required 1", wraps); end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        logic found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (hc[1] == 11'd300 && vc[1] == 11'd8) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_reach: got timeout required h=300 v=8");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (obs[1] !== {11'd0, 11'd0, 6'b011100}) begin
            errors++;
            $display("FAIL mid_reset_state: got %h required %h", obs[1], {11'd0, 11'd0, 6'b011100});
        end
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (fs[1]) found = 1'b1;
        end
        checks++;
        if (!found || cyc != 16000) begin
            errors++;
            $display("FAIL first_frame_after_reset: got %0d required 16000", cyc);
        end
    endtask

    initial begin
        reset = 1'b1;
        fork
            scoreboard();
        join_none
        test_reset();
        test_default_hsync();
        test_div2();
        test_small_mode();
        test_two_frames();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
